// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtractor that works on one DIGIT-bit slice per cycle,
// LSB first, keeping the inter-slice carry in a register.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits added per cycle (WIDTH % DIGIT == 0)
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake (in_ready only in IDLE)
//   a, b, sub              operands; sub = 1 computes a - b
//   sat                    saturate on signed overflow (only with ADDSUB_SAT_EN)
//   out_valid / out_ready  result handshake (out_valid only in DONE)
//   s                      result
//   c_out                  carry out of the MSB (1 = no borrow when subtracting)
//   of                     signed overflow (unsaturated)
//   zero, neg              derived from the final, possibly saturated, s
//
// Build option: define ADDSUB_SAT_EN to add the sat port and saturating results.
module addsub_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             of,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q, s_q;
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;
  logic              in_ready_q, out_valid_q;
  logic              c_out_q, of_q, zero_q, neg_q;
`ifdef ADDSUB_SAT_EN
  logic              sat_q;
`endif

  logic [DIGIT-1:0]  a_dig, b_dig;
  logic [DIGIT:0]    dig_sum;
  logic [WIDTH-1:0]  res_d, s_fin;
  logic              last_dig, cin_msb, of_fin;

  always_comb begin
    a_dig    = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig    = b_q[cnt_q*DIGIT +: DIGIT];
    dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    res_d    = res_q;
    res_d[cnt_q*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
    last_dig = (cnt_q == CntW'(NDIG - 1));
    // Result MSB = a ^ b' ^ cin, so the carry into the MSB is recovered from the sum bit.
    // Only meaningful on the last digit, where the MSB sits at the top of the slice.
    cin_msb  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ dig_sum[DIGIT-1];
    of_fin   = cin_msb ^ dig_sum[DIGIT];
    s_fin    = res_d;
`ifdef ADDSUB_SAT_EN
    if (sat_q && of_fin) begin
      s_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_out_q     <= 1'b0;
      of_q        <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            // Subtraction as a + ~b + 1: the +1 enters through the initial carry.
            b_q        <= sub ? ~b : b;
            carry_q    <= sub;
            cnt_q      <= '0;
`ifdef ADDSUB_SAT_EN
            sat_q      <= sat;
`endif
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          res_q   <= res_d;
          carry_q <= dig_sum[DIGIT];
          cnt_q   <= cnt_q + CntW'(1);
          if (last_dig) begin
            s_q         <= s_fin;
            c_out_q     <= dig_sum[DIGIT];
            of_q        <= of_fin;
            zero_q      <= (s_fin == '0);
            neg_q       <= s_fin[WIDTH-1];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign of        = of_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: three instances (DIGIT = 8, 1, 32) share one operand stream.
module tb_addsub_seq;
  localparam int unsigned W = 32;
`ifdef ADDSUB_SAT_EN
  localparam bit SatOn = 1'b1;
`else
  localparam bit SatOn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready, sub, sat;
  logic [W-1:0] a, b;

  logic         rdy8, vld8, c8, of8, z8, n8;
  logic         rdy1, vld1, c1, of1, z1, n1;
  logic         rdy32, vld32, c32, of32, z32, n32;
  logic [W-1:0] s8, s1, s32;

  addsub_seq #(.WIDTH(W), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .a(a), .b(b), .sub(sub),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(vld8), .out_ready(out_ready), .s(s8), .c_out(c8), .of(of8),
    .zero(z8), .neg(n8));

  addsub_seq #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .sub(sub),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(vld1), .out_ready(out_ready), .s(s1), .c_out(c1), .of(of1),
    .zero(z1), .neg(n1));

  addsub_seq #(.WIDTH(W), .DIGIT(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .a(a), .b(b), .sub(sub),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(vld32), .out_ready(out_ready), .s(s32), .c_out(c32), .of(of32),
    .zero(z32), .neg(n32));

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, sat;
    logic [W-1:0] s;
    logic         c, ovf, z, n;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb_q[$];
  vec_t tbl[17];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t vec(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                               input logic sub_v, input logic sat_v, input logic [W-1:0] s_v,
                               input logic c_v, input logic o_v, input logic z_v,
                               input logic n_v);
    vec_t r;
    r.a = a_v; r.b = b_v; r.sub = sub_v; r.sat = sat_v;
    r.s = s_v; r.c = c_v; r.ovf = o_v; r.z = z_v; r.n = n_v;
    return r;
  endfunction

  // Reference: full-width add, overflow from operand/result sign agreement.
  function automatic vec_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                 input logic sub_v, input logic sat_v);
    vec_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb    = sub_v ? ~b_v : b_v;
    full  = {1'b0, a_v} + {1'b0, bb} + {{W{1'b0}}, sub_v};
    r.a   = a_v; r.b = b_v; r.sub = sub_v; r.sat = sat_v;
    r.s   = full[W-1:0];
    r.c   = full[W];
    r.ovf = (a_v[W-1] == bb[W-1]) && (full[W-1] != a_v[W-1]);
    if (SatOn && sat_v && r.ovf) r.s = a_v[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    r.z   = (r.s == '0);
    r.n   = r.s[W-1];
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input int hold);
    vec_t e;
    int   lat8  = -1;
    int   lat1  = -1;
    int   lat32 = -1;
    check("in_ready before accept", {rdy8, rdy1, rdy32}, 3'b111);
    a = v.a; b = v.b; sub = v.sub; sat = v.sat; in_valid = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 40 && (lat8 < 0 || lat1 < 0 || lat32 < 0); k++) begin
      @(posedge clk); #1;
      if (vld8  && lat8  < 0) lat8  = k;
      if (vld1  && lat1  < 0) lat1  = k;
      if (vld32 && lat32 < 0) lat32 = k;
    end
    check("latency digit8", lat8, 4);
    check("latency digit1", lat1, 32);
    check("latency digit32", lat32, 1);
    e = sb_q.pop_front();
    check("s digit8", s8, e.s);
    check("c_out digit8", c8, e.c);
    check("of digit8", of8, e.ovf);
    check("zero digit8", z8, e.z);
    check("neg digit8", n8, e.n);
    check("s/c/of digit1", {s1, c1, of1, z1, n1}, {e.s, e.c, e.ovf, e.z, e.n});
    check("s/c/of digit32", {s32, c32, of32, z32, n32}, {e.s, e.c, e.ovf, e.z, e.n});
    // Stall in DONE while new operands are offered; they must be ignored.
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid;
      a = $urandom; b = $urandom; sub = 1'($urandom);
      @(posedge clk); #1;
      check("hold s", s8, e.s);
      check("hold flags", {c8, of8, z8, n8}, {e.c, e.ovf, e.z, e.n});
      check("hold handshake", {vld8, rdy8, vld1, rdy1}, 4'b1010);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release to idle", {vld8, rdy8, vld32, rdy32}, 4'b0101);
    check("s held after done", s8, e.s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    #12;
    check("reset s", s8, '0);
    check("reset handshake", {rdy8, vld8}, 2'b10);
    check("reset flags", {c8, of8, z8, n8}, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl[0] = vec(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 0, 0, 0, 0);
    tbl[1] = vec(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 0, 0, 0, 1);
    tbl[2] = vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
    tbl[3] = vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 0, 1, 0, 1);
    tbl[4] = vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1,
                 SatOn ? 32'h7FFF_FFFF : 32'h8000_0000, 0, 1, 0, !SatOn);
    tbl[5] = vec(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
                 SatOn ? 32'h8000_0000 : 32'h7FFF_FFFF, 1, 1, 0, SatOn);
    tbl[6] = vec(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
    tbl[7] = vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1, 1, 1, 0);
    tbl[8] = vec(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h0246_8ACF, 1, 0, 0, 0);
    for (int i = 9; i < 17; i++) begin
      tbl[i] = model($urandom, $urandom, 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 17; i++) begin
      run_txn(tbl[i], (i == 2) ? 5 : 0);
    end

    // Abort mid-operation: reset in the second CALC cycle.
    run_txn(tbl[1], 0);
    a = 32'h0000_1111; b = 32'h0000_2222; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
    sb_q.push_back(model(a, b, sub, sat));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort s", s8, '0);
    check("abort handshake", {vld8, rdy8, vld1, rdy1}, 4'b0101);
    check("abort flags", {c8, of8, z8, n8}, 4'b0000);
    void'(sb_q.pop_front());  // aborted, no result expected
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("no result after abort", {vld8, vld1, vld32}, 3'b000);
    run_txn(model(32'hCAFE_0001, 32'h0000_BEEF, 1'b1, 1'b0), 0);
    check("scoreboard drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
